// File: rtl/cic_decim_var.sv
// cic_decim_var: single-clock CIC decimator with run-time ratio 2^d, gain normalisation and warm-up suppression
// Ports:
//   i_clk       clock, all state updates on the rising edge
//   i_rst       synchronous active-high reset
//   i_en        sample enable, one sample consumed per enabled cycle
//   i_data      signed input sample
//   i_dec_bits  requested decimation exponent, clamped to MAX_DEC_BITS, sampled on strobes
//   o_data      signed normalised output, held between valid pulses
//   o_valid     one-cycle pulse marking a new o_data
//   o_dec_bits  decimation exponent currently in effect
module cic_decim_var #(
    parameter int I_WIDTH      = 1,
    parameter int ORDER        = 3,
    parameter int MAX_DEC_BITS = 8,
    parameter int O_WIDTH      = 16,
    parameter int REG_WIDTH    = I_WIDTH + ORDER * MAX_DEC_BITS,
    parameter int D_WIDTH      = $clog2(MAX_DEC_BITS + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic [I_WIDTH-1:0] i_data,
    input  logic [D_WIDTH-1:0] i_dec_bits,
    output logic [O_WIDTH-1:0] o_data,
    output logic               o_valid,
    output logic [D_WIDTH-1:0] o_dec_bits
);
    localparam int W_WIDTH = $clog2(ORDER + 1);

    logic [D_WIDTH-1:0]      dec_in;
    logic [D_WIDTH-1:0]      dec_q;
    logic [MAX_DEC_BITS-1:0] cnt;
    logic [MAX_DEC_BITS-1:0] mask;
    logic [W_WIDTH-1:0]      warm;
    logic [REG_WIDTH-1:0]    integ     [ORDER];
    logic [REG_WIDTH-1:0]    integ_nxt [ORDER];
    logic [REG_WIDTH-1:0]    dly       [ORDER];
    logic [REG_WIDTH-1:0]    comb      [ORDER+1];
    logic [REG_WIDTH-1:0]    norm;
    logic [31:0]             shamt;
    logic                    strobe;
    logic                    change;

    // The comb input is the last integrator's next value, so the strobe
    // sample is part of the frame; the comb chain settles in the same cycle.
    always_comb begin
        dec_in = (i_dec_bits > D_WIDTH'(MAX_DEC_BITS)) ? D_WIDTH'(MAX_DEC_BITS) : i_dec_bits;
        mask = ~({MAX_DEC_BITS{1'b1}} << dec_q);
        strobe = i_en && ((cnt & mask) == mask);
        change = strobe && (dec_in != dec_q);
        integ_nxt[0] = integ[0] + {{(REG_WIDTH-I_WIDTH){i_data[I_WIDTH-1]}}, i_data};
        for (int k = 1; k < ORDER; k++)
            integ_nxt[k] = integ[k] + integ_nxt[k-1];
        comb[0] = integ_nxt[ORDER-1];
        for (int k = 0; k < ORDER; k++)
            comb[k+1] = comb[k] - dly[k];
        // Gain is 2^(ORDER*d); shifting up to the MAX_DEC_BITS gain keeps full scale fixed.
        shamt = ORDER * (MAX_DEC_BITS - 32'(dec_q));
        norm = comb[ORDER] << shamt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < ORDER; k++) begin
                integ[k] <= '0;
                dly[k]   <= '0;
            end
            cnt     <= '0;
            dec_q   <= dec_in;
            warm    <= W_WIDTH'(ORDER);
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (change) begin
                for (int k = 0; k < ORDER; k++) begin
                    integ[k] <= '0;
                    dly[k]   <= '0;
                end
                cnt   <= '0;
                dec_q <= dec_in;
                warm  <= W_WIDTH'(ORDER);
            end else if (i_en) begin
                cnt <= cnt + MAX_DEC_BITS'(1);
                for (int k = 0; k < ORDER; k++)
                    integ[k] <= integ_nxt[k];
                if (strobe) begin
                    for (int k = 0; k < ORDER; k++)
                        dly[k] <= comb[k];
                    o_data  <= O_WIDTH'(norm >> (REG_WIDTH - O_WIDTH));
                    o_valid <= (warm == '0);
                    if (warm != '0)
                        warm <= warm - W_WIDTH'(1);
                end
            end
        end
    end

    assign o_dec_bits = dec_q;
endmodule

// File: doc/cic_decim_var.md
Name: cic_decim_var

Overview:
Single-clock, parametrised successor to the fixed-ratio CIC decimator. The decimation ratio is selectable at run time as 2^d, with d from 0 to MAX_DEC_BITS. There is no derived clock: the comb section runs on a decimation strobe in the i_clk domain and outputs are qualified by o_valid. Output is gain-normalised so full scale is independent of d, and warm-up samples are suppressed. The block sits between the sigma-delta bitstream (or a wider modulator word) and downstream FIR/readout logic.

Parameters:
I_WIDTH, 1, input sample width (signed two's complement)
ORDER, 3, number of integrator and comb stages (M)
MAX_DEC_BITS, 8, largest decimation exponent; max ratio = 2^MAX_DEC_BITS
O_WIDTH, 16, output width; must be <= REG_WIDTH
REG_WIDTH, I_WIDTH+ORDER*MAX_DEC_BITS, internal accumulator width (derived; do not override)
D_WIDTH, $clog2(MAX_DEC_BITS+1), width of the ratio select

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  synchronous, active-high reset
i_en  in  1  sample enable; one input sample is consumed per cycle with i_en=1
i_data  in  I_WIDTH  signed input sample
i_dec_bits  in  D_WIDTH  requested decimation exponent d; values > MAX_DEC_BITS clamp to MAX_DEC_BITS
o_data  out  O_WIDTH  signed normalised output, held between valid pulses
o_valid  out  1  one-cycle pulse marking a new o_data
o_dec_bits  out  D_WIDTH  exponent currently in effect (dec_q)

Behaviour:
- Reset (i_rst=1 at an edge):
  - integrators, comb delays, decimation counter, o_data and o_valid all clear to 0;
  - dec_q loads the clamped i_dec_bits;
  - warm-up counter loads ORDER.
  - Reset has priority over every other event, including mid-frame and on a strobe cycle.
- i_en=0: all state holds, no strobe, o_valid=0.
- Integrators: ORDER cascaded registers, y_k <= y_k + y_(k-1)_in, modulo 2^REG_WIDTH. Stage 0 input is i_data sign-extended to REG_WIDTH. They update only when i_en=1. Wrap-around is intentional and must not saturate.
- Counter: MAX_DEC_BITS wide, increments on i_en. Strobe s = i_en & (cnt[dec_q-1:0] == all ones). For dec_q=0, s = i_en.
- Sample capture: on a cycle with s=1, the comb input captures the next value of the last integrator. That value includes the current sample, so each frame holds exactly 2^dec_q samples.
- Comb section: ORDER stages, z_k = x_k - delay_k, modulo 2^REG_WIDTH. The delays update only on s and the chain is combinational, so the result is available in the strobe cycle.
- Normalisation: full = comb output. Form norm = full << (ORDER*(MAX_DEC_BITS-dec_q)), truncated to REG_WIDTH. o_data = norm[REG_WIDTH-1 -: O_WIDTH], i.e. truncation toward -inf with no rounding.
- Output timing: o_data registers on the edge ending the strobe cycle, and o_valid=1 for exactly that following cycle. Latency is 1 cycle from the strobe to o_valid.
- Warm-up: while the warm-up counter is nonzero, a strobe decrements it and o_valid stays 0. o_data still updates. The first valid output is therefore the (ORDER+1)th strobe after reset or a ratio change.
- Ratio change: i_dec_bits is sampled only on strobe cycles. If the clamped value differs from dec_q, then at that edge:
  - dec_q takes the new value;
  - integrators, comb delays and the counter clear;
  - the warm-up counter reloads ORDER;
  - o_valid=0 for the following cycle, and that frame's output is discarded.
  - Changes between strobes are ignored until the next strobe.
- Simultaneous strobe and ratio change: the ratio change wins and no valid output is produced.
- Counter bits above dec_q keep counting freely and have no effect.

Test Plan:
Setup for all scenarios: I_WIDTH=4, ORDER=3, MAX_DEC_BITS=4, O_WIDTH=16 (REG_WIDTH=16).
1. Reset, d=4, i_en=1 constantly, i_data=+1 -> strobes on cycles 15, 31, 47, 63; first o_valid on cycle 64 with o_data=4096; then every 16 cycles, always 4096; no o_valid before cycle 64.
2. Same as 1 with d=2 -> strobe every 4 cycles; first o_valid at cycle 16 with o_data=4096 (gain 64 shifted left by 6); proves normalisation.
3. d=4, i_data=-8 then +7 constant (after warm-up each) -> o_data=-32768 and 28672; accumulator wrap-around occurs internally and is not visible at the output.
4. i_en toggled 1/0 every cycle, d=4, i_data=+1 -> o_valid spacing 32 cycles, o_data=4096; state holds while i_en=0.
5. Steady at d=4; i_dec_bits changed to 1 mid-frame -> no effect until the next strobe; at that strobe o_dec_bits=1 with no o_valid; 3 further strobes are suppressed, then o_data=4096. i_dec_bits=15 -> clamps to 4.
6. i_rst asserted for 1 cycle mid-frame, including on a strobe cycle -> the next cycle has o_valid=0, o_data=0 and the counter at 0; the warm-up sequence of scenario 1 repeats exactly.
